// File: rtl/spi_pkg.sv
// Shared definitions for the register-SPI initiator: FSM state encoding,
// frame geometry constants, the latched frame layout and a frame-length helper.
package spi_pkg;

  localparam int unsigned INSTR_BITS = 16;
  localparam int unsigned ADDR_W     = 13;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned MAX_BYTES  = 4;
  localparam int unsigned DATA_W     = BYTE_W * MAX_BYTES;
  localparam int unsigned FRAME_W    = INSTR_BITS + DATA_W;
  localparam int unsigned BIT_CNT_W  = 6;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_HIGH  = 3'd2,
    ST_LOW   = 3'd3,
    ST_HOLD  = 3'd4,
    ST_GAP   = 3'd5
  } spi_state_e;

  // Serial frame, MSB first: instruction word followed by up to four data bytes.
  typedef struct packed {
    logic              rd_wr;
    logic [1:0]        w1w0;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } spi_frame_t;

  // Index of the last rising edge of a frame carrying (w1w0+1) data bytes.
  function automatic logic [BIT_CNT_W-1:0] last_bit_idx(input logic [1:0] w1w0);
    return BIT_CNT_W'(INSTR_BITS + BYTE_W * (32'(w1w0) + 32'd1) - 32'd1);
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Half-period timer shared by every timed FSM state.
// Ports: clk, resetb (async active-low), load / load_val (restart the count),
//        tick_c (combinational, high while the count is at zero).
module spi_clk_div #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             tick_c
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Down-count to zero and park there until the next load.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign tick_c = (cnt_q == '0);

endmodule

// File: rtl/spi_master_initiator.sv
// Register-SPI initiator: sends {R/W, W1W0, 13-bit addr, 1..4 data bytes}
// MSB-first on sdo, drives sclk (idle low) and csb, and shifts read bytes
// from the open-drain sdi into rd_data.
// Ports: clk, resetb (async active-low); start/rd_wr/w1w0/addr/wr_data command
//        (sampled on accepted start); busy, done, rd_data status; sclk, csb,
//        sdo, sdi serial pins. All outputs are registered.
// Build option: SPI_MISO_SYNC_EN adds a 2-flop sdi synchronizer and moves the
//        read capture to the last clk cycle of the sclk-high half period.
module spi_master_initiator
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned CSB_GAP = 8
) (
  input  logic              clk,
  input  logic              resetb,
  input  logic              start,
  input  logic              rd_wr,
  input  logic [1:0]        w1w0,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rd_data,
  output logic              sclk,
  output logic              csb,
  output logic              sdo,
  input  logic              sdi
);

  localparam int unsigned DIV_MAX = (CSB_GAP > CLK_DIV) ? CSB_GAP : CLK_DIV;
  localparam int unsigned CNT_W   = $clog2(DIV_MAX + 1);

  if (CLK_DIV < 2 || CLK_DIV > 255) begin : g_bad_clk_div
    $error("spi_master_initiator: CLK_DIV must be within 2..255");
  end
  if (CSB_GAP < 1) begin : g_bad_csb_gap
    $error("spi_master_initiator: CSB_GAP must be at least 1");
  end

  spi_state_e           state_q, state_d;
  logic [FRAME_W-1:0]   sr_q, sr_d;
  logic [BIT_CNT_W-1:0] bit_q, bit_d;
  logic [BIT_CNT_W-1:0] last_q, last_d;
  logic                 is_rd_q, is_rd_d;
  logic                 sclk_q, sclk_d;
  logic                 csb_q, csb_d;
  logic                 sdo_q, sdo_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [DATA_W-1:0]    rd_data_q, rd_data_d;

  logic                 tick_c;
  logic                 load_c;
  logic [CNT_W-1:0]     load_val_c;
  logic                 miso_c;
  logic                 cap_c;
  spi_frame_t           frame_c;

  // Every state change restarts the timer; GAP is timed in CSB_GAP cycles.
  assign load_c     = (state_d != state_q);
  assign load_val_c = (state_d == ST_GAP) ? CNT_W'(CSB_GAP - 1) : CNT_W'(CLK_DIV - 1);

  spi_clk_div #(
    .CNT_W (CNT_W)
  ) u_clk_div (
    .clk      (clk),
    .resetb   (resetb),
    .load     (load_c),
    .load_val (load_val_c),
    .tick_c   (tick_c)
  );

`ifdef SPI_MISO_SYNC_EN
  if (CLK_DIV < 3) begin : g_bad_sync_div
    $error("spi_master_initiator: SPI_MISO_SYNC_EN needs CLK_DIV >= 3");
  end

  // Idle value 1 matches the board pull-up on the open-drain line.
  logic [1:0] sync_q;
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) sync_q <= 2'b11;
    else         sync_q <= {sync_q[0], sdi};
  end
  assign miso_c = sync_q[1];

  // Late capture leaves the synchronizer time to settle after the target drives.
  assign cap_c = (state_q == ST_HIGH) && tick_c && is_rd_q &&
                 (bit_q >= BIT_CNT_W'(INSTR_BITS));
`else
  assign miso_c = sdi;

  // Capture on the edge that raises sclk; bit_q+1 is that edge's index.
  assign cap_c = (state_q == ST_LOW) && tick_c && is_rd_q &&
                 (bit_q >= BIT_CNT_W'(INSTR_BITS - 1));
`endif

  // Frame image loaded on start; reads carry an all-zero data field.
  always_comb begin
    frame_c       = '0;
    frame_c.rd_wr = rd_wr;
    frame_c.w1w0  = w1w0;
    frame_c.addr  = addr;
    frame_c.data  = rd_wr ? '0 : wr_data;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start)  state_d = ST_SETUP;
      ST_SETUP: if (tick_c) state_d = ST_HIGH;
      ST_HIGH:  if (tick_c) state_d = (bit_q == last_q) ? ST_HOLD : ST_LOW;
      ST_LOW:   if (tick_c) state_d = ST_HIGH;
      ST_HOLD:  if (tick_c) state_d = ST_GAP;
      ST_GAP:   if (tick_c) state_d = ST_IDLE;
      default:              state_d = ST_IDLE;
    endcase
  end

  // FSM output and datapath next values.
  always_comb begin
    sr_d      = sr_q;
    bit_d     = bit_q;
    last_d    = last_q;
    is_rd_d   = is_rd_q;
    sclk_d    = sclk_q;
    csb_d     = csb_q;
    sdo_d     = sdo_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    rd_data_d = rd_data_q;

    if (cap_c) rd_data_d = {rd_data_q[DATA_W-2:0], miso_c};

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          sr_d    = frame_c;
          bit_d   = '0;
          last_d  = last_bit_idx(w1w0);
          is_rd_d = rd_wr;
          csb_d   = 1'b0;
          sdo_d   = rd_wr;
          busy_d  = 1'b1;
        end
      end
      ST_SETUP: begin
        if (tick_c) sclk_d = 1'b1;
      end
      ST_HIGH: begin
        if (tick_c) begin
          sclk_d = 1'b0;
          // Next bit goes out with the falling edge.
          if (bit_q != last_q) begin
            sr_d  = sr_q << 1;
            sdo_d = sr_d[FRAME_W-1];
          end
        end
      end
      ST_LOW: begin
        if (tick_c) begin
          sclk_d = 1'b1;
          bit_d  = bit_q + BIT_CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (tick_c) begin
          csb_d  = 1'b1;
          done_d = 1'b1;
        end
      end
      ST_GAP: begin
        if (tick_c) busy_d = 1'b0;
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      sr_q      <= '0;
      bit_q     <= '0;
      last_q    <= '0;
      is_rd_q   <= 1'b0;
      sclk_q    <= 1'b0;
      csb_q     <= 1'b1;
      sdo_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_data_q <= '0;
    end else begin
      sr_q      <= sr_d;
      bit_q     <= bit_d;
      last_q    <= last_d;
      is_rd_q   <= is_rd_d;
      sclk_q    <= sclk_d;
      csb_q     <= csb_d;
      sdo_q     <= sdo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign rd_data = rd_data_q;
  assign sclk    = sclk_q;
  assign csb     = csb_q;
  assign sdo     = sdo_q;

endmodule

// File: tb/tb_spi_master_initiator.sv
// Bench for spi_master_initiator: directed frames from the test plan plus
// random frames, checked against a frame-level model and an open-drain target.
`timescale 1ns/1ps
module tb_spi_master_initiator;

`ifdef SPI_MISO_SYNC_EN
  localparam int unsigned CLK_DIV = 3;
`else
  localparam int unsigned CLK_DIV = 4;
`endif
  localparam int unsigned CSB_GAP     = 8;
  localparam int          FRAME_LIMIT = 3000;

  logic        clk = 1'b0;
  logic        resetb = 1'b0;
  logic        start = 1'b0;
  logic        rd_wr = 1'b0;
  logic [1:0]  w1w0 = 2'd0;
  logic [12:0] addr = 13'd0;
  logic [31:0] wr_data = 32'd0;
  logic        busy, done, sclk, csb, sdo, sdi;
  logic [31:0] rd_data;

  int checks = 0;
  int failures = 0;

  logic [7:0]  resp [4];
  logic [31:0] model_rd = 32'd0;

  always #5 clk = ~clk;

  spi_master_initiator #(
    .CLK_DIV (CLK_DIV),
    .CSB_GAP (CSB_GAP)
  ) dut (
    .clk     (clk),
    .resetb  (resetb),
    .start   (start),
    .rd_wr   (rd_wr),
    .w1w0    (w1w0),
    .addr    (addr),
    .wr_data (wr_data),
    .busy    (busy),
    .done    (done),
    .rd_data (rd_data),
    .sclk    (sclk),
    .csb     (csb),
    .sdo     (sdo),
    .sdi     (sdi)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Open-drain target: decodes R/W from the first bit, drives read bytes
  // after each falling edge, releases the line whenever csb is high.
  logic tgt_drv_low = 1'b0;
  logic tgt_rw = 1'b0;
  logic tgt_sclk_prev = 1'b0;
  int   tgt_edges = 0;
  int   tgt_k;
  logic [7:0] tgt_byte;
  assign sdi = tgt_drv_low ? 1'b0 : 1'b1;

  always @(sclk or csb) begin
    if (csb !== 1'b0) begin
      tgt_drv_low = 1'b0;
      tgt_edges   = 0;
    end else if (sclk && !tgt_sclk_prev) begin
      tgt_edges++;
      if (tgt_edges == 1) tgt_rw = sdo;
    end else if (!sclk && tgt_sclk_prev) begin
      tgt_drv_low = 1'b0;
      if (tgt_rw && tgt_edges >= 16 && tgt_edges < 48) begin
        tgt_k       = tgt_edges - 16;
        tgt_byte    = resp[tgt_k / 8];
        tgt_drv_low = !tgt_byte[7 - (tgt_k % 8)];
      end
    end
    tgt_sclk_prev = sclk;
  end

  // Issues (or continues) one frame and checks it end to end.
  task automatic run_frame(input string tag, input logic rw, input logic [1:0] ww,
                           input logic [12:0] a, input logic [31:0] wd,
                           input bit skip_start, input bit hold_start,
                           output logic [47:0] bits_o, output int gap_o);
    int n, nb, edges, csb_low, gap, dones, cyc;
    logic prev_sclk;
    logic [47:0] exp_bits, got_bits;
    nb = int'(ww) + 1;
    n  = 16 + 8 * nb;
    exp_bits = {rw, ww, a, (rw ? 32'h0 : wd)};
    got_bits = '0;
    edges = 0; csb_low = 0; gap = 0; dones = 0; cyc = 0;
    prev_sclk = 1'b0;
    if (!skip_start) begin
      rd_wr = rw; w1w0 = ww; addr = a; wr_data = wd;
      start = 1'b1;
    end
    @(negedge clk);
    if (!hold_start) start = 1'b0;
    while (cyc < FRAME_LIMIT) begin
      if (sclk && !prev_sclk) begin
        if (edges < 48) got_bits[47 - edges] = sdo;
        edges++;
      end
      prev_sclk = sclk;
      if (!csb) csb_low++;
      if (csb && busy) gap++;
      if (done) dones++;
      if (!busy) break;
      @(negedge clk);
      cyc++;
    end
    if (rw) for (int i = 0; i < nb; i++) model_rd = {model_rd[23:0], resp[i]};
    check({tag, "_in_time"}, 64'(cyc < FRAME_LIMIT), 64'd1);
    check({tag, "_edges"}, 64'(edges), 64'(n));
    check({tag, "_sdo_bits"}, 64'(got_bits >> (48 - n)), 64'(exp_bits >> (48 - n)));
    check({tag, "_csb_low"}, 64'(csb_low), 64'(CLK_DIV * (2 * n + 1)));
    check({tag, "_done_pulses"}, 64'(dones), 64'd1);
    check({tag, "_busy_gap"}, 64'(gap), 64'(CSB_GAP));
    check({tag, "_rd_data"}, 64'(rd_data), 64'(model_rd));
    bits_o = got_bits;
    gap_o  = gap;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [47:0] bits;
    int gap, edges, cyc, dones;
    logic prev;

    resetb = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_rd_data", 64'(rd_data), 64'd0);
    check("rst_sclk", 64'(sclk), 64'd0);
    check("rst_csb", 64'(csb), 64'd1);
    check("rst_sdo", 64'(sdo), 64'd0);
    resetb = 1'b1;
    @(negedge clk);

    // One-byte write: 0,00,0000000010100,10100101.
    run_frame("wr1", 1'b0, 2'd0, 13'h0014, 32'hA500_0000, 1'b0, 1'b0, bits, gap);
    check("wr1_seq", 64'(bits[47:24]), 64'h0014A5);

    // Two-byte read returning 3C, C3.
    resp[0] = 8'h3C; resp[1] = 8'hC3; resp[2] = 8'h00; resp[3] = 8'h00;
    run_frame("rd2", 1'b1, 2'd1, 13'h0100, 32'hFFFF_FFFF, 1'b0, 1'b0, bits, gap);
    check("rd2_low16", 64'(rd_data[15:0]), 64'h3CC3);
    check("rd2_sdo_data_zero", 64'(bits[31:16]), 64'd0);

    // Four-byte write.
    run_frame("wr4", 1'b0, 2'd3, 13'h1ABC, 32'hDEAD_BEEF, 1'b0, 1'b0, bits, gap);
    check("wr4_bytes", 64'(bits[31:0]), 64'hDEAD_BEEF);

    // start held high: the next frame may only begin from IDLE.
    run_frame("b2b_a", 1'b0, 2'd1, 13'h0777, 32'h1234_5678, 1'b0, 1'b1, bits, gap);
    check("b2b_csb_gap_min", 64'(gap + 1 >= int'(CSB_GAP)), 64'd1);
    run_frame("b2b_b", 1'b0, 2'd1, 13'h0777, 32'h1234_5678, 1'b1, 1'b0, bits, gap);
    repeat (4) @(negedge clk);
    check("b2b_no_queue", 64'(busy), 64'd0);

    // Reset in the middle of a read frame.
    for (int j = 0; j < 4; j++) resp[j] = 8'($urandom);
    rd_wr = 1'b1; w1w0 = 2'd3; addr = 13'($urandom); wr_data = $urandom;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    edges = 0; cyc = 0; prev = 1'b0;
    while (edges < 10 && cyc < FRAME_LIMIT) begin
      @(negedge clk);
      cyc++;
      if (sclk && !prev) edges++;
      prev = sclk;
    end
    check("rstmid_reached_bit10", 64'(edges), 64'd10);
    #2 resetb = 1'b0;
    #1;
    check("rstmid_csb", 64'(csb), 64'd1);
    check("rstmid_sclk", 64'(sclk), 64'd0);
    check("rstmid_busy", 64'(busy), 64'd0);
    dones = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) dones++;
    end
    resetb = 1'b1;
    model_rd = 32'd0;
    repeat (2) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("rstmid_no_done", 64'(dones), 64'd0);
    check("rstmid_rd_cleared", 64'(rd_data), 64'd0);
    run_frame("after_rst", 1'b0, 2'd2, 13'h0ACE, 32'hC0FF_EE00, 1'b0, 1'b0, bits, gap);

    // Random frames of all lengths and directions.
    for (int i = 0; i < 10; i++) begin
      logic        r_rw;
      logic [1:0]  r_ww;
      logic [12:0] r_a;
      logic [31:0] r_wd;
      r_rw = 1'($urandom_range(0, 1));
      r_ww = 2'($urandom_range(0, 3));
      r_a  = 13'($urandom);
      r_wd = $urandom;
      for (int j = 0; j < 4; j++) resp[j] = 8'($urandom);
      run_frame($sformatf("rand%0d", i), r_rw, r_ww, r_a, r_wd, 1'b0, 1'b0, bits, gap);
      repeat ($urandom_range(0, 5)) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
